icw_ocw_control_sequencer: RTL

//  Command-word sequencer for the 8259A core. Consumes the decoded write strobes and

---
 rtl/icw_ocw_control_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/icw_ocw_control_sequencer.sv
// Command-word sequencer for the 8259A core: walks ICW1..ICW4 initialization,
// then routes OCW1/OCW2/OCW3 writes and holds all programmed configuration.
//
// state     | meaning
// IDLE      | out of reset, waiting for ICW1
// WAIT_ICW2 | ICW1 taken, next A0=1 write is ICW2
// WAIT_ICW3 | cascade mode, next A0=1 write is ICW3
// WAIT_ICW4 | IC4 set, next A0=1 write is ICW4
// READY     | initialized, A0=1 writes are OCW1
module icw_ocw_control_sequencer #(
  parameter logic [7:0] MASK_AFTER_ICW1 = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] internal_data_bus,
  input  logic       write_initial_command_word_1,
  input  logic       write_initial_command_word_2_4,
  input  logic       write_operation_control_word_1,
  input  logic       write_operation_control_word_2,
  input  logic       write_operation_control_word_3,
  output logic       init_done,
  output logic       level_or_edge_triggered,
  output logic       single_mode,
  output logic [4:0] interrupt_vector_base,
  output logic [7:0] cascade_config,
  output logic       u8086_mode,
  output logic       auto_eoi,
  output logic       buffered_mode,
  output logic       buffered_master,
  output logic       special_fully_nested,
  output logic [7:0] interrupt_mask,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_command,
  output logic [2:0] ocw2_level,
  output logic       rotate_on_aeoi,
  output logic       special_mask_mode,
  output logic       read_isr_select,
  output logic       poll_command
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       ltim_q, ltim_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic [4:0] vec_q, vec_d;
  logic [7:0] cas_q, cas_d;
  logic [4:0] icw4_q, icw4_d;
  logic [7:0] mask_q, mask_d;
  logic       ocw2_valid_q, ocw2_valid_d;
  logic [2:0] cmd_q, cmd_d;
  logic [2:0] lvl_q, lvl_d;
  logic       rot_q, rot_d;
  logic       smm_q, smm_d;
  logic       ris_q, ris_d;
  logic       poll_q, poll_d;

  always_comb begin
    state_d      = state_q;
    ltim_d       = ltim_q;
    sngl_d       = sngl_q;
    ic4_d        = ic4_q;
    vec_d        = vec_q;
    cas_d        = cas_q;
    icw4_d       = icw4_q;
    mask_d       = mask_q;
    ocw2_valid_d = 1'b0;
    cmd_d        = cmd_q;
    lvl_d        = lvl_q;
    rot_d        = rot_q;
    smm_d        = smm_q;
    ris_d        = ris_q;
    poll_d       = 1'b0;

    if (write_initial_command_word_1) begin
      // ICW1 restarts the sequence from any state and wins over every other strobe
      ltim_d  = internal_data_bus[3];
      sngl_d  = internal_data_bus[1];
      ic4_d   = internal_data_bus[0];
      cas_d   = 8'h00;
      icw4_d  = 5'h00;
      rot_d   = 1'b0;
      smm_d   = 1'b0;
      ris_d   = 1'b0;
      mask_d  = MASK_AFTER_ICW1;
      state_d = WAIT_ICW2;
    end else begin
      case (state_q)
        WAIT_ICW2: if (write_initial_command_word_2_4) begin
          vec_d = internal_data_bus[7:3];
          if (!sngl_q)    state_d = WAIT_ICW3;
          else if (ic4_q) state_d = WAIT_ICW4;
          else            state_d = READY;
        end
        WAIT_ICW3: if (write_initial_command_word_2_4) begin
          cas_d   = internal_data_bus;
          state_d = ic4_q ? WAIT_ICW4 : READY;
        end
        WAIT_ICW4: if (write_initial_command_word_2_4) begin
          icw4_d  = internal_data_bus[4:0];
          state_d = READY;
        end
        READY: begin
          if (write_operation_control_word_1) mask_d = internal_data_bus;
          if (write_operation_control_word_2) begin
            cmd_d        = internal_data_bus[7:5];
            lvl_d        = internal_data_bus[2:0];
            ocw2_valid_d = 1'b1;
            if (internal_data_bus[7:5] == 3'b100)      rot_d = 1'b1;
            else if (internal_data_bus[7:5] == 3'b000) rot_d = 1'b0;
          end
          if (write_operation_control_word_3) begin
            if (internal_data_bus[6]) smm_d = internal_data_bus[5];
            if (internal_data_bus[1]) ris_d = internal_data_bus[0];
            poll_d = internal_data_bus[2];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ltim_q       <= 1'b0;
      sngl_q       <= 1'b0;
      ic4_q        <= 1'b0;
      vec_q        <= 5'h00;
      cas_q        <= 8'h00;
      icw4_q       <= 5'h00;
      mask_q       <= MASK_AFTER_ICW1;
      ocw2_valid_q <= 1'b0;
      cmd_q        <= 3'h0;
      lvl_q        <= 3'h0;
      rot_q        <= 1'b0;
      smm_q        <= 1'b0;
      ris_q        <= 1'b0;
      poll_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ltim_q       <= ltim_d;
      sngl_q       <= sngl_d;
      ic4_q        <= ic4_d;
      vec_q        <= vec_d;
      cas_q        <= cas_d;
      icw4_q       <= icw4_d;
      mask_q       <= mask_d;
      ocw2_valid_q <= ocw2_valid_d;
      cmd_q        <= cmd_d;
      lvl_q        <= lvl_d;
      rot_q        <= rot_d;
      smm_q        <= smm_d;
      ris_q        <= ris_d;
      poll_q       <= poll_d;
    end
  end

  assign init_done               = (state_q == READY);
  assign level_or_edge_triggered = ltim_q;
  assign single_mode             = sngl_q;
  assign interrupt_vector_base   = vec_q;
  assign cascade_config          = cas_q;
  assign u8086_mode              = icw4_q[0];
  assign auto_eoi                = icw4_q[1];
  assign buffered_master         = icw4_q[2];
  assign buffered_mode           = icw4_q[3];
  assign special_fully_nested    = icw4_q[4];
  assign interrupt_mask          = mask_q;
  assign ocw2_valid              = ocw2_valid_q;
  assign ocw2_command            = cmd_q;
  assign ocw2_level              = lvl_q;
  assign rotate_on_aeoi          = rot_q;
  assign special_mask_mode       = smm_q;
  assign read_isr_select         = ris_q;
  assign poll_command            = poll_q;

endmodule
